btn_event_gen: RTL
==================

Name: btn_event_gen

Overview:
- Consumes the clean, synchronous level from the button debouncer and turns it into one-cycle events for the alarm-clock control FSM: press, release, short press, long press, auto-repeat.
- Sits between each debouncer instance and the time/alarm-setting logic. Gives that logic single-cycle strobes instead of levels.
- Auto-repeat lets a held SET/UP button step minutes or hours continuously.

Parameters:
- LONG_CYCLES, 50_000_000: clk cycles of continuous hold from press_pulse to long_pulse; must be >= 2.
- REPEAT_CYCLES, 10_000_000: clk cycles between long_pulse and the first repeat_pulse, and between successive repeat_pulses; must be >= 2.
- CW (localparam): $clog2(max(LONG_CYCLES, REPEAT_CYCLES)); width of the hold counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low; clears all state
- btn_level  in  1  debounced button level, synchronous to clk; 1 = pressed
- repeat_en  in  1  1 = auto-repeat enabled while in LONG_HOLD
- press_pulse  out  1  one-cycle strobe on press
- release_pulse  out  1  one-cycle strobe on any release
- short_pulse  out  1  one-cycle strobe on release before the long threshold
- long_pulse  out  1  one-cycle strobe, once per hold, at the long threshold
- repeat_pulse  out  1  one-cycle strobe, periodic while held past the long threshold
- held  out  1  level; 1 while state != IDLE

Behaviour:
- All outputs are registered. Reset (reset = 0, asynchronous):
  - all pulse outputs = 0, held = 0
  - state = IDLE, cnt = 0, btn_q = 0
- Edge detection: btn_q <= btn_level every cycle; rise = btn_level & ~btn_q.
  - btn_q resets to 0, so a button held through reset release produces a press_pulse.
- Pulse outputs default to 0 every cycle; each is 1 for exactly one cycle per event.
- FSM states (enum): IDLE, PRESSED, LONG_HOLD.
- IDLE:
  - on rise: press_pulse <= 1, cnt <= 0, go to PRESSED. Otherwise hold.
- PRESSED (evaluated in priority order):
  - btn_level = 0: release_pulse <= 1, short_pulse <= 1, go to IDLE.
  - else if cnt == LONG_CYCLES-1: long_pulse <= 1, cnt <= 0, go to LONG_HOLD.
  - else cnt <= cnt+1.
- LONG_HOLD (evaluated in priority order):
  - btn_level = 0: release_pulse <= 1 only (no short_pulse), go to IDLE.
  - else if repeat_en = 0: cnt <= 0, stay in LONG_HOLD.
  - else if cnt == REPEAT_CYCLES-1: repeat_pulse <= 1, cnt <= 0.
  - else cnt <= cnt+1.
- Latency:
  - press_pulse is high the cycle after the first clk edge that samples btn_level = 1.
  - long_pulse goes high exactly LONG_CYCLES cycles after press_pulse.
  - repeat_pulse goes high REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
  - release and short pulses go high the cycle after the first edge that samples btn_level = 0.
- Simultaneous events:
  - Release wins over the threshold. A release on the cycle cnt reaches LONG_CYCLES-1 gives short_pulse + release_pulse and no long_pulse.
  - A release on the repeat threshold gives release_pulse and no repeat_pulse.
- repeat_en toggled mid-hold: deassertion clears cnt. Re-assertion restarts a full REPEAT_CYCLES interval.
- Counter never wraps: it is cleared at every threshold, so CW bits suffice.
- Reset mid-hold aborts silently; no release or short pulse is emitted.
- Only one of short_pulse, long_pulse, repeat_pulse is high in any cycle. press_pulse and release_pulse are never high in the same cycle.
- held = 1 from the press_pulse cycle through the cycle before release_pulse. held = 0 in the release_pulse cycle.

Decomposition:
- Shared package alarm_pkg:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESSED, LONG_HOLD}
  - default timing constants BTN_LONG_CYCLES and BTN_REPEAT_CYCLES, used by top-level instantiation
- No sub-module. Edge detect, FSM and counter stay in one file, with a separate comb next-state block and ff block.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, repeat_en=1 unless stated):
- Short press: btn_level high for 5 cycles then low -> press_pulse once; release_pulse + short_pulse together once, 5 cycles after press_pulse; no long or repeat pulse.
- Long hold: btn_level high for 20 cycles ->
  - long_pulse 8 cycles after press_pulse
  - repeat_pulse at +12 and +16
  - release_pulse alone, no short_pulse
- Threshold collision: btn_level goes low so it is first sampled on the cycle cnt == 7 -> short_pulse + release_pulse; long_pulse never asserted.
- repeat_en = 0 during a 20-cycle hold -> long_pulse once, zero repeat_pulses. Raising repeat_en at cycle 14 -> first repeat_pulse 4 cycles later.
- Reset mid-hold: assert reset low at cycle 10 of a hold -> all outputs 0 immediately, without waiting for clk. After release with btn_level still 1 -> press_pulse on the first clk edge.
- Back-to-back presses: high 3 / low 1 / high 3 -> two press_pulses, two short_pulses, held low for exactly one cycle between presses.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and timing defaults for the alarm-clock button path
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HOLD = 2'd2
  } btn_state_t;

  // 1 s long-press and 200 ms repeat at a 50 MHz system clock
  localparam int BTN_LONG_CYCLES   = 50_000_000;
  localparam int BTN_REPEAT_CYCLES = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_gen.sv
// rtl/btn_event_gen.sv - turns a debounced button level into press/release/short/long/repeat strobes
module btn_event_gen
  import alarm_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_CYCLES,
  parameter int REPEAT_CYCLES = BTN_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic repeat_en,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int CW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  btn_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          btn_q;
  logic          rise;
  logic          press_n, release_n, short_n, long_n, repeat_n;

  assign rise = btn_level & ~btn_q;
  assign held = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    short_n   = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          press_n = 1'b1;
          cnt_n   = '0;
          state_n = PRESSED;
        end
      end
      PRESSED: begin
        // a release landing on the threshold still counts as a short press
        if (!btn_level) begin
          release_n = 1'b1;
          short_n   = 1'b1;
          state_n   = IDLE;
        end else if (cnt == LONG_LAST) begin
          long_n  = 1'b1;
          cnt_n   = '0;
          state_n = LONG_HOLD;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LONG_HOLD: begin
        if (!btn_level) begin
          release_n = 1'b1;
          state_n   = IDLE;
        end else if (!repeat_en) begin
          cnt_n = '0;
        end else if (cnt == REPEAT_LAST) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_q         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_q         <= btn_level;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_pulse   <= short_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
    end
  end

endmodule
